// File: rtl/sha256_msg_loader.sv
// Purpose: fetch up to MAX_MESSAGE_LENGTH bytes, apply SHA-256 padding, stream one 512-bit block as 16 BE words.
// Latency: 2 cycles per message byte, 1 per pad byte, 1 per emitted word; done in cycle 81+L with ready held high.
// Backpressure: word_valid holds word_data/word_index stable until word_ready; build with SHA256_LOADER_ABORT_EN for the abort input.
module sha256_msg_loader #(
    parameter int MAX_MESSAGE_LENGTH = 55,
    parameter int AW = $clog2(MAX_MESSAGE_LENGTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] msg_length,
`ifdef SHA256_LOADER_ABORT_EN
    input  logic          abort,
`endif
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_data,
    output logic          word_valid,
    input  logic          word_ready,
    output logic [31:0]   word_data,
    output logic [3:0]    word_index,
    output logic          busy,
    output logic          done,
    output logic          err
);
    typedef enum logic [2:0] {S_IDLE, S_BYTE, S_WAIT, S_EMIT, S_DONE} state_t;

    localparam logic [AW:0] MAX_LEN = MAX_MESSAGE_LENGTH[AW:0];

    state_t      state;
    state_t      state_nxt;
    logic [6:0]  pos;        // byte position within the 64-byte block
    logic [6:0]  len;        // latched message length
    logic [31:0] shreg;      // word assembly, newest byte in the low lane
    logic [7:0]  pad_byte;
    logic [9:0]  bit_len;
    logic        len_ok;
    logic        pos_in_msg;
    logic        word_full;
    logic        abort_act;

`ifdef SHA256_LOADER_ABORT_EN
    assign abort_act = abort;
`else
    assign abort_act = 1'b0;
`endif

    assign len_ok     = ({1'b0, msg_length} <= MAX_LEN);
    assign pos_in_msg = (pos < len);
    // The byte shifted in this cycle completes the current word.
    assign word_full  = (pos[1:0] == 2'd3);
    assign bit_len    = {len, 3'b000};
    assign word_data  = shreg;

    // Generated padding: 0x80 terminator, zero fill, big-endian bit length in the last bytes.
    always_comb begin
        pad_byte = 8'h00;
        if (pos == len)
            pad_byte = 8'h80;
        else if (pos == 7'd62)
            pad_byte = {6'b000000, bit_len[9:8]};
        else if (pos == 7'd63)
            pad_byte = bit_len[7:0];
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; abort overrides every other transition outside IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start && len_ok) state_nxt = S_BYTE;
            S_BYTE: begin
                if (pos_in_msg)
                    state_nxt = S_WAIT;
                else
                    state_nxt = word_full ? S_EMIT : S_BYTE;
            end
            S_WAIT: state_nxt = word_full ? S_EMIT : S_BYTE;
            S_EMIT: if (word_ready) state_nxt = (word_index == 4'd15) ? S_DONE : S_BYTE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort_act && (state != S_IDLE))
            state_nxt = S_IDLE;
    end

    // Outputs decoded from the current state only, so word_valid never depends on word_ready.
    always_comb begin
        mem_rd_en  = 1'b0;
        mem_addr   = '0;
        word_valid = 1'b0;
        busy       = (state != S_IDLE);
        done       = 1'b0;
        case (state)
            S_BYTE: if (pos_in_msg) begin
                mem_rd_en = 1'b1;
                mem_addr  = pos[AW-1:0];
            end
            S_EMIT: word_valid = 1'b1;
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: length latch, byte position, word assembly and word counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            len        <= '0;
            pos        <= '0;
            shreg      <= '0;
            word_index <= '0;
        end else begin
            case (state)
                S_IDLE: if (start && len_ok) begin
                    len        <= 7'(msg_length);
                    pos        <= '0;
                    word_index <= '0;
                end
                S_BYTE: if (!pos_in_msg) begin
                    shreg <= {shreg[23:0], pad_byte};
                    pos   <= pos + 7'd1;
                end
                S_WAIT: begin
                    shreg <= {shreg[23:0], mem_data};
                    pos   <= pos + 7'd1;
                end
                S_EMIT: if (word_ready && !abort_act && (word_index != 4'd15))
                    word_index <= word_index + 4'd1;
                default: ;
            endcase
        end
    end

    // Rejected start reports one cycle later without leaving IDLE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            err <= 1'b0;
        else
            err <= (state == S_IDLE) && start && !len_ok;
    end

endmodule
